// File: rtl/wb_unit_pipelined.sv
// Writeback stage: picks a result source or waits for a load response, extracts and
// extends the load data, and drives a registered register-file write port. WB_FWD_EN adds the pending-load hazard outputs.
module wb_unit_pipelined #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 15,
  localparam int SEL_W  = $clog2(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        ResultSrcW,
  input  logic [2:0]              LoadControlW,
  input  logic [NUM_SRC*XLEN-1:0] SrcDataW,
  input  logic [4:0]              RdW,
  input  logic                    RegWriteW,
  input  logic                    rdata_valid,
  input  logic [XLEN-1:0]         rdata,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    load_err,
`ifdef WB_FWD_EN
  output logic                    fwd_pending,
  output logic [4:0]              fwd_rd,
`endif
  output logic [1:0]              dbgState
);

  // Handshake: an entry transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on the FSM state, never on in_valid.

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic [4:0]       capRd;
  logic             capWe;
  logic [2:0]       capCtl;
  logic [1:0]       capOff;
  logic [XLEN-1:0]  selData;
  logic             accept;
  logic             isLoad;
  logic             timeoutHit;

  assign accept     = in_valid && in_ready;
  assign isLoad     = (ResultSrcW == SEL_W'(1));
  assign timeoutHit = (state == WAIT_LOAD) && !rdata_valid && (waitCnt == CNT_LAST);

  function automatic logic [XLEN-1:0] extractLoad(input logic [2:0] ctl,
                                                  input logic [1:0] off,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (ctl)
      3'b000:  extractLoad = {{(XLEN-8){b[7]}}, b};
      3'b001:  extractLoad = {{(XLEN-16){h[15]}}, h};
      3'b100:  extractLoad = {{(XLEN-8){1'b0}}, b};
      3'b101:  extractLoad = {{(XLEN-16){1'b0}}, h};
      default: extractLoad = word;
    endcase
  endfunction

  // Out-of-range selects fall through to zero.
  always_comb begin
    selData = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ResultSrcW == SEL_W'(i)) selData = SrcDataW[i*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (accept && isLoad) stateNext = WAIT_LOAD;
      WAIT_LOAD: if (rdata_valid || timeoutHit) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    dbgState = state;
`ifdef WB_FWD_EN
    fwd_pending = (state == WAIT_LOAD) && capWe && (capRd != 5'd0);
    fwd_rd      = capRd;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt  <= '0;
      capRd    <= '0;
      capWe    <= 1'b0;
      capCtl   <= '0;
      capOff   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      load_err <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      load_err <= 1'b0;
      if (accept) begin
        if (isLoad) begin
          capRd   <= RdW;
          capWe   <= RegWriteW;
          capCtl  <= LoadControlW;
          capOff  <= SrcDataW[1:0];
          waitCnt <= '0;
        end else begin
          rf_we    <= RegWriteW && (RdW != 5'd0);
          rf_waddr <= RdW;
          rf_wdata <= selData;
        end
      end
      if (state == WAIT_LOAD) begin
        if (rdata_valid) begin
          rf_we    <= capWe && (capRd != 5'd0);
          rf_waddr <= capRd;
          rf_wdata <= extractLoad(capCtl, capOff, rdata);
          waitCnt  <= '0;
        end else if (timeoutHit) begin
          load_err <= 1'b1;
          waitCnt  <= '0;
        end else begin
          waitCnt <= waitCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_unit_pipelined.sv
// Directed table-driven bench for wb_unit_pipelined: non-load and load vectors,
// then hand sequences for timeout, reset mid-wait, ignored strobes and back-to-back accepts.
module tb_wb_unit_pipelined;

  localparam int XLEN = 32;
  localparam int NUM_SRC = 4;
  localparam int SEL_W = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        ResultSrcW;
  logic [2:0]              LoadControlW;
  logic [NUM_SRC*XLEN-1:0] SrcDataW;
  logic [4:0]              RdW;
  logic                    RegWriteW;
  logic                    rdata_valid;
  logic [XLEN-1:0]         rdata;
  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic                    load_err;
  logic [1:0]              dbgState;
`ifdef WB_FWD_EN
  logic                    fwd_pending;
  logic [4:0]              fwd_rd;
`endif

  int checks = 0;
  int failures = 0;

  wb_unit_pipelined #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ResultSrcW(ResultSrcW),
    .LoadControlW(LoadControlW),
    .SrcDataW(SrcDataW),
    .RdW(RdW),
    .RegWriteW(RegWriteW),
    .rdata_valid(rdata_valid),
    .rdata(rdata),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .load_err(load_err),
`ifdef WB_FWD_EN
    .fwd_pending(fwd_pending),
    .fwd_rd(fwd_rd),
`endif
    .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   sel;
    logic [127:0] src;
    logic [4:0]   rd;
    logic         we;
    logic         expWe;
    logic [31:0]  expData;
  } aluVec_t;

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] addr;
    logic [31:0] word;
    int          delay;
    logic [4:0]  rd;
    logic        we;
    logic        expWe;
    logic [31:0] expData;
  } loadVec_t;

  aluVec_t  aluVecs[5];
  loadVec_t loadVecs[12];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    in_valid     = 1'b0;
    ResultSrcW   = '0;
    LoadControlW = '0;
    SrcDataW     = '0;
    RdW          = '0;
    RegWriteW    = 1'b0;
    rdata_valid  = 1'b0;
    rdata        = '0;
  endtask

  // driver: one non-load entry, then check the one-cycle write
  task automatic runAlu(input aluVec_t v, input int idx);
    in_valid   = 1'b1;
    ResultSrcW = v.sel;
    SrcDataW   = v.src;
    RdW        = v.rd;
    RegWriteW  = v.we;
    check($sformatf("alu%0d_ready", idx), 32'(in_ready), 32'd1);
    step();
    idleInputs();
    check($sformatf("alu%0d_we", idx), 32'(rf_we), 32'(v.expWe));
    if (v.expWe) begin
      check($sformatf("alu%0d_waddr", idx), 32'(rf_waddr), 32'(v.rd));
      check($sformatf("alu%0d_wdata", idx), rf_wdata, v.expData);
    end
    step();
    check($sformatf("alu%0d_we_drop", idx), 32'(rf_we), 32'd0);
  endtask

  // driver: one load entry answered after v.delay empty wait cycles
  task automatic runLoad(input loadVec_t v, input int idx);
    in_valid     = 1'b1;
    ResultSrcW   = 2'd1;
    LoadControlW = v.ctl;
    SrcDataW     = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, v.addr};
    RdW          = v.rd;
    RegWriteW    = v.we;
    check($sformatf("ld%0d_ready", idx), 32'(in_ready), 32'd1);
    step();
    idleInputs();
    for (int k = 0; k < v.delay; k++) begin
      check($sformatf("ld%0d_wait_ready", idx), 32'(in_ready), 32'd0);
      check($sformatf("ld%0d_wait_we", idx), 32'(rf_we), 32'd0);
`ifdef WB_FWD_EN
      check($sformatf("ld%0d_fwd_pending", idx), 32'(fwd_pending), 32'(v.we && v.rd != 5'd0));
`endif
      step();
    end
    rdata_valid = 1'b1;
    rdata       = v.word;
    check($sformatf("ld%0d_resp_ready", idx), 32'(in_ready), 32'd0);
    step();
    idleInputs();
    check($sformatf("ld%0d_we", idx), 32'(rf_we), 32'(v.expWe));
    if (v.expWe) begin
      check($sformatf("ld%0d_waddr", idx), 32'(rf_waddr), 32'(v.rd));
      check($sformatf("ld%0d_wdata", idx), rf_wdata, v.expData);
    end
    check($sformatf("ld%0d_ready_back", idx), 32'(in_ready), 32'd1);
    step();
    check($sformatf("ld%0d_we_drop", idx), 32'(rf_we), 32'd0);
  endtask

  initial begin
    aluVecs[0] = '{2'd0, {32'hA5A5A5A5, 32'h0BADF00D, 32'hFFFFFFFF, 32'h12345678}, 5'd5,  1'b1, 1'b1, 32'h12345678};
    aluVecs[1] = '{2'd2, {32'hA5A5A5A5, 32'h0BADF00D, 32'hFFFFFFFF, 32'h12345678}, 5'd31, 1'b1, 1'b1, 32'h0BADF00D};
    aluVecs[2] = '{2'd3, {32'hA5A5A5A5, 32'h0BADF00D, 32'hFFFFFFFF, 32'h12345678}, 5'd1,  1'b1, 1'b1, 32'hA5A5A5A5};
    aluVecs[3] = '{2'd0, {32'hA5A5A5A5, 32'h0BADF00D, 32'hFFFFFFFF, 32'h12345678}, 5'd0,  1'b1, 1'b0, 32'h0};
    aluVecs[4] = '{2'd2, {32'hA5A5A5A5, 32'h0BADF00D, 32'hFFFFFFFF, 32'h12345678}, 5'd4,  1'b0, 1'b0, 32'h0};

    loadVecs[0]  = '{3'b000, 32'h10000003, 32'h80FF7F01, 3, 5'd5,  1'b1, 1'b1, 32'hFFFFFF80};
    loadVecs[1]  = '{3'b101, 32'h10000002, 32'hBEEF1234, 1, 5'd6,  1'b1, 1'b1, 32'h0000BEEF};
    loadVecs[2]  = '{3'b001, 32'h10000002, 32'hBEEF1234, 0, 5'd7,  1'b1, 1'b1, 32'hFFFFBEEF};
    loadVecs[3]  = '{3'b100, 32'h10000000, 32'h80FF7F01, 2, 5'd8,  1'b1, 1'b1, 32'h00000001};
    loadVecs[4]  = '{3'b100, 32'h10000003, 32'h80FF7F01, 0, 5'd9,  1'b1, 1'b1, 32'h00000080};
    loadVecs[5]  = '{3'b000, 32'h10000002, 32'h80FF7F01, 1, 5'd10, 1'b1, 1'b1, 32'hFFFFFFFF};
    loadVecs[6]  = '{3'b001, 32'h10000001, 32'h80FF7F01, 0, 5'd11, 1'b1, 1'b1, 32'h00007F01};
    loadVecs[7]  = '{3'b001, 32'h10000003, 32'h80010002, 1, 5'd12, 1'b1, 1'b1, 32'hFFFF8001};
    loadVecs[8]  = '{3'b010, 32'h10000001, 32'hCAFEF00D, 0, 5'd13, 1'b1, 1'b1, 32'hCAFEF00D};
    loadVecs[9]  = '{3'b011, 32'h10000002, 32'h11223344, 2, 5'd14, 1'b1, 1'b1, 32'h11223344};
    loadVecs[10] = '{3'b010, 32'h10000000, 32'h55AA55AA, 1, 5'd0,  1'b1, 1'b0, 32'h0};
    loadVecs[11] = '{3'b010, 32'h10000000, 32'h55AA55AA, 2, 5'd3,  1'b0, 1'b0, 32'h0};

    idleInputs();
    rst_n = 1'b0;
    step();
    step();
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_we", 32'(rf_we), 32'd0);
    check("reset_waddr", 32'(rf_waddr), 32'd0);
    check("reset_wdata", rf_wdata, 32'd0);
    check("reset_load_err", 32'(load_err), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) runAlu(aluVecs[i], i);
    for (int i = 0; i < 12; i++) runLoad(loadVecs[i], i);

    // timeout: 15 empty wait cycles, then a single load_err pulse
    in_valid = 1'b1; ResultSrcW = 2'd1; LoadControlW = 3'b010;
    SrcDataW = {96'h0, 32'h20000000}; RdW = 5'd9; RegWriteW = 1'b1;
    step();
    idleInputs();
    for (int k = 0; k < 15; k++) begin
      check("to_wait_ready", 32'(in_ready), 32'd0);
      check("to_wait_err", 32'(load_err), 32'd0);
      step();
    end
    check("to_err_pulse", 32'(load_err), 32'd1);
    check("to_no_write", 32'(rf_we), 32'd0);
    check("to_ready_back", 32'(in_ready), 32'd1);
    step();
    check("to_err_drop", 32'(load_err), 32'd0);

    // strobe in the acceptance cycle must be ignored
    in_valid = 1'b1; ResultSrcW = 2'd1; LoadControlW = 3'b010;
    SrcDataW = {96'h0, 32'h20000000}; RdW = 5'd17; RegWriteW = 1'b1;
    rdata_valid = 1'b1; rdata = 32'hDEADBEEF;
    step();
    idleInputs();
    check("acc_strobe_no_we", 32'(rf_we), 32'd0);
    check("acc_strobe_still_wait", 32'(in_ready), 32'd0);
    rdata_valid = 1'b1; rdata = 32'h01020304;
    step();
    // back-to-back: accept a non-load in the cycle after the load returns
    in_valid = 1'b1; ResultSrcW = 2'd2; SrcDataW = {32'h0, 32'h77778888, 32'h0, 32'h0};
    RdW = 5'd18; RegWriteW = 1'b1;
    check("b2b_load_we", 32'(rf_we), 32'd1);
    check("b2b_load_waddr", 32'(rf_waddr), 32'd17);
    check("b2b_load_wdata", rf_wdata, 32'h01020304);
    check("b2b_ready", 32'(in_ready), 32'd1);
    step();
    idleInputs();
    check("b2b_alu_we", 32'(rf_we), 32'd1);
    check("b2b_alu_waddr", 32'(rf_waddr), 32'd18);
    check("b2b_alu_wdata", rf_wdata, 32'h77778888);
    step();
    check("b2b_we_drop", 32'(rf_we), 32'd0);

    // reset during WAIT_LOAD discards the pending load
    in_valid = 1'b1; ResultSrcW = 2'd1; LoadControlW = 3'b010;
    SrcDataW = {96'h0, 32'h20000000}; RdW = 5'd21; RegWriteW = 1'b1;
    step();
    idleInputs();
    step();
    check("rst_mid_pre_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    check("rst_mid_we", 32'(rf_we), 32'd0);
    check("rst_mid_waddr", 32'(rf_waddr), 32'd0);
    check("rst_mid_wdata", rf_wdata, 32'd0);
    check("rst_mid_err", 32'(load_err), 32'd0);
`ifdef WB_FWD_EN
    check("rst_mid_fwd_pending", 32'(fwd_pending), 32'd0);
    check("rst_mid_fwd_rd", 32'(fwd_rd), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    rdata_valid = 1'b1; rdata = 32'hFEEDFACE;
    step();
    idleInputs();
    check("rst_late_resp_no_we", 32'(rf_we), 32'd0);
    check("rst_late_ready", 32'(in_ready), 32'd1);
    step();
    check("rst_late_no_we2", 32'(rf_we), 32'd0);
    check("rst_late_no_err", 32'(load_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_unit_pipelined.md
Name: wb_unit_pipelined

Overview:
Parametrised writeback stage for the RV32I pipeline. It selects the writeback result from NUM_SRC sources, with source 1 reserved for load data. Load data arrives from a variable-latency memory response channel and is aligned and sign/zero-extended inside the block. Output is a registered register-file write port with a valid/ready handshake back to the MEM/WB boundary.

Parameters:
XLEN, 32, datapath width; only 32 is supported for load extraction.
NUM_SRC, 4, number of result sources; SEL_W = $clog2(NUM_SRC).
TIMEOUT, 15, maximum cycles to wait for a load response before aborting.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  MEM/WB entry valid
in_ready  out  1  entry accepted when in_valid && in_ready
ResultSrcW  in  SEL_W  source select; 1 = load
LoadControlW  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
SrcDataW  in  NUM_SRC*XLEN  flattened sources; slice 0 = ALU result (address), slice 1 ignored
RdW  in  5  destination register
RegWriteW  in  1  write enable from decode
rdata_valid  in  1  load response strobe
rdata  in  XLEN  raw aligned word from memory
rf_we  out  1  register-file write enable, registered
rf_waddr  out  5  write address, registered
rf_wdata  out  XLEN  write data, registered
load_err  out  1  one-cycle pulse on load timeout

Behaviour:
- Reset, asynchronous, while rst_n=0: state=IDLE, timeout counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, load_err=0, all captured fields cleared. Applies mid-wait as well; any pending load is discarded.
- in_ready = (state==IDLE).
- IDLE, non-load accepted at edge N:
  - rf_we=RegWriteW && (RdW!=0) during cycle N+1, for exactly one cycle.
  - rf_wdata = SrcDataW slice[ResultSrcW]. Select values >= NUM_SRC give 0.
- IDLE, load accepted (ResultSrcW==1):
  - Capture RdW, RegWriteW, LoadControlW, and offset = slice0[1:0].
  - Go to WAIT_LOAD with counter=0. rf_we=0.
- WAIT_LOAD:
  - rdata_valid is sampled only in this state; a strobe in the acceptance cycle is ignored.
  - On rdata_valid: extract, register write data, assert rf_we (captured enable && rd!=0) in the next cycle, return to IDLE. Back-to-back acceptance is possible in the cycle after the return.
  - Otherwise the counter increments. If it reaches TIMEOUT with no response: load_err=1 for one cycle, no write, return to IDLE.
- Extraction:
  - LB/LBU: byte[offset], sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: halfword at offset[1] (offset[0] ignored), sign- or zero-extended.
  - LW: full word, offset ignored.
  - Undefined LoadControl values: full word.
- rf_we is never high for more than one cycle per accepted entry. Every accepted entry produces exactly one rf_we pulse or one load_err pulse, except when suppressed by rd=0 or RegWriteW=0.

Optional Feature:
WB_FWD_EN defined: adds outputs fwd_pending (1 bit) and fwd_rd (5 bits).
- fwd_pending=1 while in WAIT_LOAD with captured RegWriteW=1 and rd!=0.
- fwd_rd = captured rd, for hazard stalling upstream.
- Both reset to 0.
WB_FWD_EN undefined: the ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Non-load, sel=0, slice0=0x12345678, rd=5, RegWrite=1 -> next cycle rf_we=1, waddr=5, wdata=0x12345678; following cycle rf_we=0.
- LB, address 0x...3, response after 3 cycles with rdata=0x80FF7F01 -> in_ready low for 4 cycles; then wdata=0xFFFFFF80, rf_we one cycle.
- LHU, offset 2, rdata=0xBEEF1234 -> 0x0000BEEF. LH, offset 2, same data -> 0xFFFFBEEF.
- Load with no response -> after 15 wait cycles load_err pulses once, rf_we stays 0, in_ready returns to 1.
- rd=0 with RegWrite=1 (both load and non-load) -> rf_we stays 0; load path still consumes its response.
- rst_n asserted low during WAIT_LOAD -> immediately IDLE, all outputs 0; a later rdata_valid causes no write.
